// File: rtl/prog_loader.sv
// Program loader: fills word-addressed memory from a byte stream
// (count, little-endian payload, XOR checksum) and pulses start on success.
module prog_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              arm,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              start,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;

    typedef enum logic [2:0] {
        IDLE, CNT_LO, CNT_HI, DATA, CSUM, START, DONE, ERR
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       cnt_q;
    logic [1:0]        byte_q;
    logic [ADDR_W-1:0] word_q;
    logic [23:0]       buf_q;
    logic [7:0]        csum_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;

    logic        acc;
    logic        arm_go;
    logic [15:0] n_full;
    logic        cnt_bad;
    logic        last_word;

    assign acc       = in_valid && in_ready;
    assign arm_go    = arm && (state_q == IDLE || state_q == DONE || state_q == ERR);
    assign n_full    = {in_data, cnt_q[7:0]};
    assign cnt_bad   = (n_full == 16'd0) || ({1'b0, n_full} > DEPTH);
    assign last_word = (16'(word_q) == cnt_q - 16'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        busy     = 1'b0;
        start    = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        case (state_q)
            IDLE: if (arm) state_d = CNT_LO;
            CNT_LO: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) state_d = CNT_HI;
            end
            CNT_HI: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) state_d = cnt_bad ? ERR : DATA;
            end
            DATA: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid && byte_q == 2'd3 && last_word) state_d = CSUM;
            end
            CSUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) state_d = (in_data == csum_q) ? START : ERR;
            end
            START: begin
                busy    = 1'b1;
                start   = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (arm) state_d = CNT_LO;
            end
            ERR: begin
                err = 1'b1;
                if (arm) state_d = CNT_LO;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            byte_q      <= '0;
            word_q      <= '0;
            buf_q       <= '0;
            csum_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            mem_we_q <= 1'b0;
            if (arm_go) begin
                byte_q     <= '0;
                word_q     <= '0;
                mem_addr_q <= '0;
                csum_q     <= '0;
            end
            if (acc) begin
                case (state_q)
                    CNT_LO: cnt_q[7:0]  <= in_data;
                    CNT_HI: cnt_q[15:8] <= in_data;
                    DATA: begin
                        csum_q <= csum_q ^ in_data;
                        byte_q <= byte_q + 2'd1;
                        case (byte_q)
                            2'd0: buf_q[7:0]   <= in_data;
                            2'd1: buf_q[15:8]  <= in_data;
                            2'd2: buf_q[23:16] <= in_data;
                            default: begin
                                // fourth byte completes the word; word_q holds the next free address
                                mem_we_q    <= 1'b1;
                                mem_addr_q  <= word_q;
                                mem_wdata_q <= {in_data, buf_q};
                                word_q      <= word_q + 1'b1;
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader; writes and start pulses are
// captured by a monitor and compared against hand-computed values.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        arm = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        start, busy, done, err;

    int checks = 0;
    int errors = 0;

    prog_loader #(.ADDR_W(10)) dut (
        .clk(clk), .rst_n(rst_n), .arm(arm),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .start(start), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    logic [31:0] cap [0:1023];
    int wr_cnt, start_cnt, first_addr, last_addr;

    always @(posedge clk) begin
        if (mem_we) begin
            if (wr_cnt == 0) first_addr = int'(mem_addr);
            cap[mem_addr] = mem_wdata;
            last_addr = int'(mem_addr);
            wr_cnt++;
        end
        if (start) start_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clr_mon();
        wr_cnt = 0; start_cnt = 0; first_addr = -1; last_addr = -1;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
    endtask

    // returns at the negedge following the edge that accepted the byte
    task automatic send(input logic [7:0] b);
        logic rdy;
        int n;
        n = 0; in_data = b; in_valid = 1'b1;
        forever begin
            rdy = in_ready;
            @(posedge clk);
            @(negedge clk);
            if (rdy) break;
            n++;
            if (n > 50) begin
                chk("send_timeout", 32'(n), 32'd0);
                break;
            end
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        in_valid = 1'b0;
        while (!(done || err) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("wait_done_bound", 32'(n < 20), 32'd1);
    endtask

    logic [7:0] good [0:10] = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                                8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};

    task automatic good_load();
        clr_mon();
        pulse_arm();
        for (int i = 0; i < 11; i++) send(good[i]);
        wait_done();
    endtask

    initial begin
        clr_mon();
        #3 rst_n = 1'b0;
        #1;
        chk("rst_outputs", {25'd0, in_ready, mem_we, start, busy, done, err, 1'b0}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 32'd0);

        // good load with exact timing
        clr_mon();
        pulse_arm();
        chk("armed_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 10; i++) send(good[i]);
        chk("last_we", 32'(mem_we), 32'd1);
        chk("last_addr", 32'(mem_addr), 32'd1);
        chk("last_wdata", mem_wdata, 32'hDEADBEEF);
        send(good[10]);
        in_valid = 1'b0;
        chk("start_pulse", 32'(start), 32'd1);
        chk("done_not_yet", 32'(done), 32'd0);
        @(negedge clk);
        chk("done_level", {29'd0, start, done, err}, 32'b010);
        chk("good_w0", cap[0], 32'h12345678);
        chk("good_w1", cap[1], 32'hDEADBEEF);
        chk("good_wr_cnt", 32'(wr_cnt), 32'd2);
        chk("good_start_cnt", 32'(start_cnt), 32'd1);

        // bad checksum
        clr_mon();
        pulse_arm();
        for (int i = 0; i < 10; i++) send(good[i]);
        send(8'h2B);
        in_valid = 1'b0;
        chk("badcs_err", {29'd0, start, done, err}, 32'b001);
        @(negedge clk); @(negedge clk);
        chk("badcs_wr_cnt", 32'(wr_cnt), 32'd2);
        chk("badcs_start_cnt", 32'(start_cnt), 32'd0);
        chk("badcs_err_held", 32'(err), 32'd1);

        // zero count
        clr_mon();
        pulse_arm();
        send(8'h00); send(8'h00);
        in_valid = 1'b0;
        chk("cnt0_err", {29'd0, busy, err, in_ready}, 32'b010);
        chk("cnt0_wr_cnt", 32'(wr_cnt), 32'd0);

        // count 1025
        clr_mon();
        pulse_arm();
        send(8'h01); send(8'h04);
        in_valid = 1'b0;
        chk("cnt1025_err", 32'(err), 32'd1);
        @(negedge clk);
        chk("cnt1025_wr_cnt", 32'(wr_cnt), 32'd0);

        // recovery load after errors
        good_load();
        chk("recover_done", {30'd0, done, err}, 32'b10);
        chk("recover_first", 32'(first_addr), 32'd0);
        chk("recover_w0", cap[0], 32'h12345678);

        // stalls and ignored arm pulses
        clr_mon();
        pulse_arm();
        for (int i = 0; i < 11; i++) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if (i == 3 || i == 7 || i == 10) pulse_arm();
            send(good[i]);
        end
        wait_done();
        @(negedge clk);
        chk("stall_done", {30'd0, done, err}, 32'b10);
        chk("stall_w0", cap[0], 32'h12345678);
        chk("stall_w1", cap[1], 32'hDEADBEEF);
        chk("stall_wr_cnt", 32'(wr_cnt), 32'd2);
        chk("stall_start_cnt", 32'(start_cnt), 32'd1);

        // full depth: word i = 5A_00_0(i>>8)_(i&FF); payload XOR is 00
        clr_mon();
        pulse_arm();
        send(8'h00); send(8'h04);
        for (int i = 0; i < 1024; i++) begin
            logic [9:0] iv;
            iv = 10'(i);
            send(iv[7:0]); send({6'd0, iv[9:8]}); send(8'h00); send(8'h5A);
        end
        send(8'h00);
        wait_done();
        @(negedge clk);
        chk("full_done", {30'd0, done, err}, 32'b10);
        chk("full_wr_cnt", 32'(wr_cnt), 32'd1024);
        chk("full_last_addr", 32'(last_addr), 32'd1023);
        chk("full_w1023", cap[1023], 32'h5A0003FF);
        chk("full_w0", cap[0], 32'h5A000000);

        // reset during DATA with the third write in flight
        clr_mon();
        pulse_arm();
        send(8'h04); send(8'h00);
        for (int i = 0; i < 12; i++) send(8'(8'h10 + i));
        in_valid = 1'b0;
        chk("mid_we", 32'(mem_we), 32'd1);
        chk("mid_wdata", mem_wdata, 32'h1B1A1918);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_outputs", {26'd0, in_ready, mem_we, start, busy, done, err}, 32'd0);
        @(negedge clk);
        chk("mid_wr_cnt", 32'(wr_cnt), 32'd2);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_idle", {30'd0, in_ready, busy}, 32'd0);
        good_load();
        chk("mid_reload_first", 32'(first_addr), 32'd0);
        chk("mid_reload_w1", cap[1], 32'hDEADBEEF);
        chk("mid_reload_done", 32'(done), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
